// File: rtl/alarm_tone_sequencer.sv
// Alarm beep/snooze sequencer with key-click arbitration feeding the I2S sample input.
// All sequencing advances on frame_tick; sample/src/alarm_active are registered on the tick edge.
`timescale 1ns/1ps
module alarm_tone_sequencer #(
  parameter int unsigned TONE_HALF  = 24,
  parameter int unsigned BEEP_ON    = 4800,
  parameter int unsigned BEEP_OFF   = 4800,
  parameter int unsigned BEEPS      = 4,
  parameter int unsigned BURST_GAP  = 48000,
  parameter int unsigned SNOOZE_LEN = 28800000,
  parameter int unsigned CLICK_LEN  = 480,
  parameter logic [15:0] AMPL       = 16'h2000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_frame_tick,
  input  logic        i_alarm_req,
  input  logic        i_snooze,
  input  logic        i_click_req,
  output logic [15:0] o_sample,
  output logic        o_sample_valid,
  output logic [1:0]  o_src,
  output logic        o_alarm_active
);
  typedef enum logic [2:0] {S_IDLE, S_ON, S_OFF, S_GAP, S_SNOOZE} state_t;

  localparam logic [1:0]  SRC_SILENCE = 2'b00;
  localparam logic [1:0]  SRC_ALARM   = 2'b01;
  localparam logic [1:0]  SRC_CLICK   = 2'b10;
  localparam logic [15:0] TONE_NEG    = 16'h0 - AMPL;
  localparam logic [15:0] CLICK_LVL   = AMPL >> 1;

  state_t      r_state, w_state;
  logic [31:0] r_dur, w_dur;
  logic [31:0] r_beep_idx, w_beep_idx;
  logic [31:0] r_tone_cnt, w_tone_cnt;
  logic [31:0] r_click_cnt, w_click_cnt;
  logic        r_tone_neg, w_tone_neg;
  logic        r_snooze_pend, r_click_pend;
  logic        w_snooze_eff, w_click_eff, w_click_keep, w_expired;
  logic [15:0] r_sample, w_sample;
  logic [1:0]  r_src, w_src;
  logic        r_valid, r_active, w_active;

  // NOTE: every signal written here gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    w_snooze_eff = r_snooze_pend | i_snooze;
    w_click_eff  = r_click_pend | i_click_req;
    w_expired    = 1'b0;
    w_state      = r_state;
    w_beep_idx   = r_beep_idx;
    w_tone_neg   = 1'b0;
    w_tone_cnt   = '0;
    w_click_cnt  = '0;
    w_click_keep = 1'b0;
    w_sample     = '0;
    w_src        = SRC_SILENCE;

    case (r_state)
      S_ON:     w_expired = (r_dur >= BEEP_ON);
      S_OFF:    w_expired = (r_dur >= BEEP_OFF);
      S_GAP:    w_expired = (r_dur >= BURST_GAP);
      S_SNOOZE: w_expired = (r_dur >= SNOOZE_LEN);
      default:  w_expired = 1'b0;
    endcase

    // Priority: alarm release, then pending snooze, then timer expiry.
    if (!i_alarm_req) begin
      w_state = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:   w_state = S_ON;
        S_SNOOZE: if (w_expired) w_state = S_ON;
        default: begin
          if (w_snooze_eff) begin
            w_state = S_SNOOZE;
          end else if (w_expired) begin
            if (r_state == S_ON) w_state = (r_beep_idx == BEEPS - 1) ? S_GAP : S_OFF;
            else                 w_state = S_ON;
          end
        end
      endcase
    end

    if (w_state == S_ON && r_state != S_ON && r_state != S_OFF) w_beep_idx = '0;
    else if (w_state == S_OFF && r_state == S_ON)                w_beep_idx = r_beep_idx + 32'd1;

    if (w_state != r_state)    w_dur = 32'd1;
    else if (r_state == S_IDLE) w_dur = r_dur;
    else                        w_dur = r_dur + 32'd1;

    // Any entry into ON starts a fresh positive half period.
    if (w_state == S_ON && r_state == S_ON) begin
      if (r_tone_cnt >= TONE_HALF - 1) begin
        w_tone_neg = ~r_tone_neg;
        w_tone_cnt = '0;
      end else begin
        w_tone_neg = r_tone_neg;
        w_tone_cnt = r_tone_cnt + 32'd1;
      end
    end

    // The alarm preempts clicks; a request seen during ON waits for the first non-ON tick.
    if (w_state == S_ON)           w_click_keep = w_click_eff;
    else if (w_click_eff)          w_click_cnt  = CLICK_LEN;
    else if (r_click_cnt != '0)    w_click_cnt  = r_click_cnt - 32'd1;

    if (w_state == S_ON) begin
      w_sample = w_tone_neg ? TONE_NEG : AMPL;
      w_src    = SRC_ALARM;
    end else if (w_click_cnt != '0) begin
      w_sample = CLICK_LVL;
      w_src    = SRC_CLICK;
    end

    w_active = (w_state == S_ON) || (w_state == S_OFF) || (w_state == S_GAP);
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= S_IDLE;
      r_dur         <= '0;
      r_beep_idx    <= '0;
      r_tone_cnt    <= '0;
      r_tone_neg    <= 1'b0;
      r_click_cnt   <= '0;
      r_snooze_pend <= 1'b0;
      r_click_pend  <= 1'b0;
      r_sample      <= '0;
      r_src         <= SRC_SILENCE;
      r_active      <= 1'b0;
      r_valid       <= 1'b0;
    end else begin
      r_valid <= i_frame_tick;
      if (i_frame_tick) begin
        r_state       <= w_state;
        r_dur         <= w_dur;
        r_beep_idx    <= w_beep_idx;
        r_tone_cnt    <= w_tone_cnt;
        r_tone_neg    <= w_tone_neg;
        r_click_cnt   <= w_click_cnt;
        r_snooze_pend <= 1'b0;
        r_click_pend  <= w_click_keep;
        r_sample      <= w_sample;
        r_src         <= w_src;
        r_active      <= w_active;
      end else begin
        r_snooze_pend <= w_snooze_eff;
        r_click_pend  <= w_click_eff;
      end
    end
  end

  assign o_sample       = r_sample;
  assign o_sample_valid = r_valid;
  assign o_src          = r_src;
  assign o_alarm_active = r_active;

endmodule

// File: tb/tb_alarm_tone_sequencer.sv
// Self-checking bench: timeline-based reference model of the beep pattern and click arbitration,
// directed scenarios with literal expectations, then randomized ticks/pulses/resets.
`timescale 1ns/1ps
module tb_alarm_tone_sequencer;
  localparam int unsigned TONE_HALF  = 2;
  localparam int unsigned BEEP_ON    = 8;
  localparam int unsigned BEEP_OFF   = 4;
  localparam int unsigned BEEPS      = 2;
  localparam int unsigned BURST_GAP  = 16;
  localparam int unsigned SNOOZE_LEN = 20;
  localparam int unsigned CLICK_LEN  = 3;
  localparam logic [15:0] AMPL       = 16'h2000;

  localparam int BEEP_PITCH = BEEP_ON + BEEP_OFF;
  localparam int SOUND_SPAN = BEEPS * BEEP_PITCH - BEEP_OFF;
  localparam int PERIOD     = SOUND_SPAN + BURST_GAP;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        frame_tick = 1'b0;
  logic        alarm_req = 1'b0;
  logic        snooze = 1'b0;
  logic        click_req = 1'b0;
  logic [15:0] sample;
  logic        sample_valid;
  logic [1:0]  src;
  logic        alarm_active;

  always #5 clk = ~clk;

  alarm_tone_sequencer #(
    .TONE_HALF(TONE_HALF), .BEEP_ON(BEEP_ON), .BEEP_OFF(BEEP_OFF), .BEEPS(BEEPS),
    .BURST_GAP(BURST_GAP), .SNOOZE_LEN(SNOOZE_LEN), .CLICK_LEN(CLICK_LEN), .AMPL(AMPL)
  ) dut (
    .clk(clk), .rst(rst), .i_frame_tick(frame_tick), .i_alarm_req(alarm_req),
    .i_snooze(snooze), .i_click_req(click_req), .o_sample(sample),
    .o_sample_valid(sample_valid), .o_src(src), .o_alarm_active(alarm_active)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int tick_no  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: position inside the repeating burst timeline, snooze frame count, click frames played.
  bit          m_run, m_snz_pend, m_click_pend;
  int          m_snz, m_pos, m_click;
  logic [15:0] e_sample = '0;
  logic [1:0]  e_src = '0;
  logic        e_active = 1'b0;
  bit          e_valid = 1'b0;
  logic [15:0] prev_sample = '0;

  task automatic model_reset();
    m_run = 0; m_snz = 0; m_pos = 0; m_click = 0;
    m_snz_pend = 0; m_click_pend = 0;
  endtask

  task automatic model_tick(input bit alarm);
    bit in_pattern, in_beep, positive;
    int off;
    if (!alarm) begin
      m_run = 0; m_snz = 0;
    end else if (!m_run) begin
      m_run = 1; m_snz = 0; m_pos = 0;
    end else if (m_snz > 0) begin
      if (m_snz >= int'(SNOOZE_LEN)) begin m_snz = 0; m_pos = 0; end
      else m_snz++;
    end else if (m_snz_pend) begin
      m_snz = 1;
    end else begin
      m_pos = (m_pos + 1) % PERIOD;
    end
    m_snz_pend = 0;

    in_pattern = m_run && (m_snz == 0);
    off        = m_pos % BEEP_PITCH;
    in_beep    = in_pattern && (m_pos < SOUND_SPAN) && (off < int'(BEEP_ON));
    positive   = ((off / int'(TONE_HALF)) % 2) == 0;

    if (in_beep)                                      m_click = 0;
    else if (m_click_pend) begin m_click = 1; m_click_pend = 0; end
    else if (m_click > 0 && m_click < int'(CLICK_LEN)) m_click++;
    else                                              m_click = 0;

    if (in_beep)          begin e_sample = positive ? AMPL : 16'h0 - AMPL; e_src = 2'b01; end
    else if (m_click > 0) begin e_sample = AMPL >> 1; e_src = 2'b10; end
    else                  begin e_sample = 16'h0; e_src = 2'b00; end
    e_active = in_pattern;
  endtask

  // One clock cycle of stimulus, applied at the falling edge.
  task automatic step(input bit tick, input bit alarm, input bit snz, input bit ck);
    @(negedge clk);
    frame_tick = tick; alarm_req = alarm; snooze = snz; click_req = ck;
    if (snz) m_snz_pend = 1;
    if (ck)  m_click_pend = 1;
    if (tick) begin model_tick(alarm); tick_no++; end
    e_valid = tick;
    @(posedge clk);
  endtask

  task automatic run_tick(input bit alarm);
    step(0, alarm, 0, 0);
    step(1, alarm, 0, 0);
  endtask

  task automatic run_to(input int n, input bit alarm);
    while (tick_no < n) run_tick(alarm);
  endtask

  task automatic pin(input string name, input logic [15:0] s, input logic [1:0] sr, input logic act);
    #2;
    check({name, " sample"}, 32'(sample), 32'(s));
    check({name, " src"}, 32'(src), 32'(sr));
    check({name, " active"}, 32'(alarm_active), 32'(act));
    check({name, " model sample"}, 32'(e_sample), 32'(s));
  endtask

  task automatic do_reset(input bit tick_during);
    @(negedge clk);
    #2;
    rst = 1'b1; e_valid = 1'b0; frame_tick = tick_during; snooze = 1'b0; click_req = 1'b0;
    model_reset();
    prev_sample = '0;
    #1;
    check("reset sample", 32'(sample), 32'h0);
    check("reset src", 32'(src), 32'h0);
    check("reset valid", 32'(sample_valid), 32'h0);
    check("reset active", 32'(alarm_active), 32'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0; frame_tick = 1'b0;
    tick_no = 0;
  endtask

  // Compare process: every cycle out of reset, check the strobe and either the new outputs or a held sample.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (!rst) begin
        check("valid", 32'(sample_valid), 32'(e_valid));
        if (e_valid) begin
          check("sample", 32'(sample), 32'(e_sample));
          check("src", 32'(src), 32'(e_src));
          check("active", 32'(alarm_active), 32'(e_active));
          prev_sample = sample;
        end else begin
          check("hold", 32'(sample), 32'(prev_sample));
        end
      end
    end
  end

  logic [15:0] basic_exp [12] = '{16'h2000, 16'h2000, 16'hE000, 16'hE000, 16'h2000, 16'h2000,
                                  16'hE000, 16'hE000, 16'h0000, 16'h0000, 16'h0000, 16'h0000};

  initial begin
    bit a, tk, sz, ck;
    model_reset();

    // Basic pattern
    do_reset(0);
    for (int i = 0; i < 12; i++) begin
      run_tick(1);
      pin($sformatf("basic t%0d", tick_no), basic_exp[i], (i < 8) ? 2'b01 : 2'b00, 1'b1);
    end
    run_to(13, 1); pin("basic t13", 16'h2000, 2'b01, 1'b1);
    run_to(21, 1); pin("basic t21", 16'h0000, 2'b00, 1'b1);
    run_to(36, 1); pin("basic t36", 16'h0000, 2'b00, 1'b1);
    run_to(37, 1); pin("basic t37", 16'h2000, 2'b01, 1'b1);

    // Snooze between ticks 3 and 4
    do_reset(0);
    run_to(3, 1);
    step(0, 1, 1, 0);
    run_to(4, 1);  pin("snooze t4", 16'h0000, 2'b00, 1'b0);
    run_to(23, 1); pin("snooze t23", 16'h0000, 2'b00, 1'b0);
    run_to(24, 1); pin("snooze t24", 16'h2000, 2'b01, 1'b1);
    run_to(32, 1); pin("snooze t32 off", 16'h0000, 2'b00, 1'b1);
    run_to(36, 1); pin("snooze t36 second beep", 16'h2000, 2'b01, 1'b1);

    // Alarm release during snooze
    do_reset(0);
    run_to(3, 1);
    step(0, 1, 1, 0);
    run_to(10, 1);
    run_to(11, 0); pin("release t11", 16'h0000, 2'b00, 1'b0);
    run_to(24, 0); pin("release t24", 16'h0000, 2'b00, 1'b0);
    run_to(40, 0); pin("release t40", 16'h0000, 2'b00, 1'b0);

    // Click while idle, then click requested during ON
    do_reset(0);
    run_to(1, 0);
    step(0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      run_tick(0);
      pin($sformatf("click idle t%0d", tick_no), 16'h1000, 2'b10, 1'b0);
    end
    run_tick(0); pin("click idle end", 16'h0000, 2'b00, 1'b0);
    run_to(10, 1);
    step(0, 1, 0, 1);
    run_to(13, 1); pin("click held in ON", 16'hE000, 2'b01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      run_tick(1);
      pin($sformatf("click off t%0d", tick_no), 16'h1000, 2'b10, 1'b1);
    end
    run_tick(1); pin("click off end", 16'h0000, 2'b00, 1'b1);

    // Preemption of a running click by the alarm
    do_reset(0);
    step(0, 0, 0, 1);
    run_to(1, 0);  pin("preempt click", 16'h1000, 2'b10, 1'b0);
    run_to(2, 1);  pin("preempt alarm", 16'h2000, 2'b01, 1'b1);
    run_to(10, 1); pin("preempt no resume", 16'h0000, 2'b00, 1'b1);

    // Reset mid-beep with a tick held during reset
    do_reset(0);
    run_to(3, 1);
    do_reset(1);
    run_tick(1); pin("after reset", 16'h2000, 2'b01, 1'b1);

    // Randomized phase: back-to-back ticks, alarm toggles, snooze/click pulses, occasional resets
    do_reset(0);
    a = 1;
    for (int i = 0; i < 5000; i++) begin
      if ($urandom_range(0, 149) == 0) a = ~a;
      if ($urandom_range(0, 1999) == 0) do_reset(1);
      tk = 1'($urandom_range(0, 1));
      sz = !tk && ($urandom_range(0, 79) == 0);
      ck = !tk && ($urandom_range(0, 24) == 0);
      step(tk, a, sz, ck);
    end
    step(0, a, 0, 0);
    step(0, a, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
